wshb_frame_slave: RTL and testbench
===================================

Name: wshb_frame_slave

Overview:
- Wishbone classic-cycle responder backed by an on-chip 32-bit word memory.
- Used as the frame-buffer endpoint for the display path's Wishbone master, in simulation and on FPGA, in place of SDRAM.
- Fills itself with a known pixel pattern after reset.
- Serves reads and byte-lane writes with a configurable number of wait states.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two, at least 2.
- WAIT_STATES, 1: extra cycles inserted before ack, range 0..15.
- ADDR_W, 32: width of the byte address bus.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- cyc  in  1  Wishbone bus cycle.
- stb  in  1  Wishbone strobe.
- we  in  1  1 = write, 0 = read.
- adr  in  ADDR_W  byte address; word index = adr[$clog2(DEPTH)+1:2]; adr[1:0] ignored.
- dat_ms  in  32  write data, master to slave.
- sel  in  4  byte-lane enables for writes; sel[i] covers dat_ms[8i+7:8i].
- cti  in  3  ignored; classic cycles only.
- bte  in  2  ignored.
- dat_sm  out  32  read data, slave to master.
- ack  out  1  transfer acknowledge, one-cycle pulse.
- err  out  1  error acknowledge; tied 0 unless WSHB_SLAVE_ERR_EN is defined.
- init_done  out  1  high once the pattern fill is complete.

Behaviour:
- All outputs are registered and sampled on posedge clk.
- Reset values: ack=0, err=0, dat_sm=0, init_done=0, state=INIT, fill counter=0.

State machine, INIT:
- Writes word k = {8'h00, k zero-extended to 24 bits} for k = 0..DEPTH-1, one word per cycle.
- After writing word DEPTH-1: init_done<=1, go to IDLE.
- The fill takes exactly DEPTH cycles after rst deasserts.
- Requests during INIT are not acked; the master stalls.

State machine, IDLE:
- On cyc&stb: latch adr, we, dat_ms and sel.
- Go to WAIT if WAIT_STATES>0, otherwise go to ACK.

State machine, WAIT:
- Counts WAIT_STATES cycles, then goes to ACK.
- Dropping cyc or stb here aborts the transfer: return to IDLE, no ack, no write.

State machine, ACK:
- ack=1 for exactly one cycle, then return to IDLE.
- Write: memory bytes with sel=1 are updated at the same edge where ack rises; bytes with sel=0 keep their value.
- Read: dat_sm = mem[latched index], valid in the ack cycle and held until the next completed read.

Latency and throughput:
- Request first seen in IDLE at cycle t gives ack high at cycle t+1+WAIT_STATES.
- ack is never high two consecutive cycles.
- If stb is still high in the cycle after ack, it is treated as a new request: minimum 2+WAIT_STATES cycles per transfer.

Boundary conditions:
- Read after write to the same word returns the merged data.
- Only the latched request is served; inputs changing during WAIT or ACK have no effect.
- rst asserted in any state aborts the current transfer: ack and err go to 0, init_done goes to 0, the fill restarts and overwrites all written data.
- cyc=0 with stb=1 is ignored.

Optional Feature:
- WSHB_SLAVE_ERR_EN, defined:
  - A word index formed from adr[ADDR_W-1:2] that is >= DEPTH is out of range.
  - An out-of-range request completes with an err pulse at the exact ack timing, no ack, no memory write, dat_sm unchanged.
- WSHB_SLAVE_ERR_EN, undefined:
  - err is tied to 0.
  - Upper address bits are ignored; addresses alias modulo DEPTH words and are acked normally.

Test Plan (DEPTH=16, WAIT_STATES=2):
1. Release rst, hold cyc=stb=1, we=0, adr=0x14 -> init_done rises 16 cycles after rst deasserts; ack comes 3 cycles after the first IDLE sample, with dat_sm=32'h00000005.
2. Write adr=0x08, dat_ms=32'hBABECAFE, sel=4'b0101, then read adr=0x08 -> dat_sm=32'h00BE00FE.
3. stb held high continuously during reads from adr 0, 4, 8, ... -> ack pulses exactly every 4 cycles; dat_sm takes values 0,1,2,... in order.
4. Drop stb during WAIT after 1 cycle -> no ack; a subsequent read of the same word returns unchanged data.
5. Read adr=0x40 (word 16): without the macro, ack with dat_sm=32'h00000000 (aliases word 0); with WSHB_SLAVE_ERR_EN, err pulses at the ack timing, ack stays 0 and dat_sm is unchanged.
6. Write word 3 = 32'hFFFFFFFF, assert rst for 1 cycle during a read in WAIT -> ack never rises for that read; after the fill completes, word 3 reads 32'h00000003.

Source files
------------

// File: rtl/wshb_frame_slave_if.sv
// ============================================================================
// Module      : wshb_frame_slave_if
// Description : Wishbone classic bus bundle between the display master and the
//               frame-buffer responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wshb_frame_slave_if #(
    parameter int ADDR_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat_ms;
    logic [3:0]        sel;
    logic [2:0]        cti;
    logic [1:0]        bte;
    logic [31:0]       dat_sm;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err
    );
endinterface

`default_nettype wire

// File: rtl/wshb_frame_slave.sv
// ============================================================================
// Module      : wshb_frame_slave
// Description : Wishbone classic responder over a pattern-filled word memory,
//               with WAIT_STATES cycles before each ack. Define
//               WSHB_SLAVE_ERR_EN to err out-of-range addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wshb_frame_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    wshb_frame_slave_if.slave   bus,
    output logic                init_done
);
    localparam int c_idx_w = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_idx_w-1:0]   r_fill_cnt;
    logic [3:0]           r_wait_cnt;
    logic                 r_ack, r_init_done;
    logic [31:0]          r_dat_sm;

    logic [c_idx_w-1:0]   r_idx, w_req_idx, w_live_idx;
    logic                 r_we, w_req_we;
    logic [31:0]          r_dat, w_req_dat;
    logic [3:0]           r_sel, w_req_sel;
    logic                 w_live_req, w_latch, w_go_ack, w_req_oor;

    logic                 w_mem_we;
    logic [c_idx_w-1:0]   w_mem_idx;
    logic [31:0]          w_mem_wdata;
    logic [3:0]           w_mem_be;
    logic [31:0]          r_mem [DEPTH];

    assign w_live_req = bus.cyc & bus.stb;
    assign w_live_idx = bus.adr[c_idx_w+1:2];

    // With zero wait states the ack edge is the request edge, so serve live inputs.
    assign w_req_idx  = (r_state == ST_IDLE) ? w_live_idx : r_idx;
    assign w_req_we   = (r_state == ST_IDLE) ? bus.we     : r_we;
    assign w_req_dat  = (r_state == ST_IDLE) ? bus.dat_ms : r_dat;
    assign w_req_sel  = (r_state == ST_IDLE) ? bus.sel    : r_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_go_ack    = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_fill_cnt == c_idx_w'(DEPTH - 1)) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_live_req) begin
                    w_latch = 1'b1;
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_go_ack    = 1'b1;
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_live_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == 4'(WAIT_STATES - 1)) begin
                    w_go_ack    = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Single write port shared by the pattern fill and bus writes.
    assign w_mem_we    = (r_state == ST_INIT) | (w_go_ack & w_req_we & ~w_req_oor);
    assign w_mem_idx   = (r_state == ST_INIT) ? r_fill_cnt      : w_req_idx;
    assign w_mem_wdata = (r_state == ST_INIT) ? 32'(r_fill_cnt) : w_req_dat;
    assign w_mem_be    = (r_state == ST_INIT) ? 4'hF            : w_req_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_fill_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_ack       <= 1'b0;
            r_init_done <= 1'b0;
            r_dat_sm    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack      <= w_go_ack & ~w_req_oor;
            r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
            if (r_state == ST_INIT) begin
                r_fill_cnt <= r_fill_cnt + c_idx_w'(1);
                if (r_fill_cnt == c_idx_w'(DEPTH - 1)) r_init_done <= 1'b1;
            end
            if (w_go_ack && !w_req_oor && !w_req_we) r_dat_sm <= r_mem[w_req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_idx <= w_live_idx;
            r_we  <= bus.we;
            r_dat <= bus.dat_ms;
            r_sel <= bus.sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
        end
    end

`ifdef WSHB_SLAVE_ERR_EN
    logic w_live_oor, r_oor, r_err;

    if (ADDR_W > c_idx_w + 2) begin : g_oor_bits
        assign w_live_oor = |bus.adr[ADDR_W-1:c_idx_w+2];
    end else begin : g_oor_none
        assign w_live_oor = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_latch) r_oor <= w_live_oor;
    end

    assign w_req_oor = (r_state == ST_IDLE) ? w_live_oor : r_oor;

    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_go_ack & w_req_oor;
    end

    assign bus.err = r_err;
`else
    assign w_req_oor = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // Classic cycles only: burst hints and byte offset carry no meaning here.
    wire w_unused = ^{bus.cti, bus.bte, bus.adr};

    assign bus.ack    = r_ack;
    assign bus.dat_sm = r_dat_sm;
    assign init_done  = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_wshb_frame_slave.sv
// ============================================================================
// Module      : tb_wshb_frame_slave
// Description : Directed, table-driven bench for wshb_frame_slave
//               (DEPTH=16, WAIT_STATES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wshb_frame_slave;
    localparam int DEPTH       = 16;
    localparam int WAIT_STATES = 2;
    localparam int ADDR_W      = 32;
    localparam int LAT         = 1 + WAIT_STATES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done;

    wshb_frame_slave_if #(.ADDR_W(ADDR_W)) bus ();

    wshb_frame_slave #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic e, input logic c, input logic [31:0] x);
        vecs[i].we      = w;
        vecs[i].adr     = a;
        vecs[i].dat     = d;
        vecs[i].sel     = s;
        vecs[i].exp_err = e;
        vecs[i].chk_dat = c;
        vecs[i].exp_dat = x;
    endtask

    task automatic drive_idle();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    // One classic transfer: drive, wait (bounded) for ack/err, release, confirm single-cycle pulse.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic got_ack, output logic got_err, output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w;
        bus.adr = a; bus.dat_ms = d; bus.sel = s;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            lat = n;
            if (bus.ack || bus.err) break;
        end
        got_ack = bus.ack;
        got_err = bus.err;
        rd      = bus.dat_sm;
        drive_idle();
        @(negedge clk);
        chk("resp_single_cycle", {30'b0, bus.ack, bus.err}, 32'd0);
    endtask

    logic        a_ack, a_err;
    logic [31:0] a_rd;
    int          a_lat;
    int          n_done;
    logic        seen;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
        bus.adr = 32'h14; bus.dat_ms = 32'h0; bus.sel = 4'h0;
        bus.cti = 3'b000; bus.bte = 2'b00;

        // Expected results; out-of-range rows differ with the error option.
        set_vec(0,  1'b0, 32'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000);
        set_vec(1,  1'b0, 32'h3C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0000000F);
        set_vec(2,  1'b1, 32'h08, 32'hBABECAFE, 4'h5, 1'b0, 1'b0, 32'h0);
        set_vec(3,  1'b0, 32'h08, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00BE00FE);
        set_vec(4,  1'b1, 32'h0C, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0);
        set_vec(5,  1'b0, 32'h0C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678);
        set_vec(6,  1'b1, 32'h10, 32'hAABBCCDD, 4'h8, 1'b0, 1'b0, 32'h0);
        set_vec(7,  1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b1, 32'hAA000004);
`ifdef WSHB_SLAVE_ERR_EN
        set_vec(8,  1'b0, 32'h40, 32'h0,        4'h0, 1'b1, 1'b1, 32'hAA000004);
        set_vec(9,  1'b0, 32'h1C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000007);
        set_vec(10, 1'b0, 32'h4C, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000007);
        set_vec(11, 1'b1, 32'h44, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0);
        set_vec(12, 1'b0, 32'h04, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000001);
`else
        set_vec(8,  1'b0, 32'h40, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000000);
        set_vec(9,  1'b0, 32'h1C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h00000007);
        set_vec(10, 1'b0, 32'h4C, 32'h0,        4'h0, 1'b0, 1'b1, 32'h12345678);
        set_vec(11, 1'b1, 32'h44, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0);
        set_vec(12, 1'b0, 32'h04, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF);
`endif

        // Reset values, then fill while a read of word 5 is already pending.
        repeat (3) @(negedge clk);
        chk("reset_ack",       {31'b0, bus.ack},   32'd0);
        chk("reset_err",       {31'b0, bus.err},   32'd0);
        chk("reset_dat_sm",    bus.dat_sm,         32'd0);
        chk("reset_init_done", {31'b0, init_done}, 32'd0);
        rst = 1'b0;
        n_done = 0;
        seen   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.ack) seen = 1'b1;
            if (init_done) begin n_done = n; break; end
        end
        chk("fill_cycles",  n_done,         32'd16);
        chk("ack_in_init",  {31'b0, seen},  32'd0);
        a_lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            a_lat = n;
            if (bus.ack) break;
        end
        chk("first_ack_latency", a_lat,      LAT);
        chk("first_read_data",   bus.dat_sm, 32'h00000005);
        drive_idle();
        @(negedge clk);
        chk("first_ack_single", {31'b0, bus.ack}, 32'd0);

        // Back-to-back reads with stb held high: one ack every 2+WAIT_STATES cycles.
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0;
        for (int k = 0; k < 6; k++) begin
            a_lat = 0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                a_lat = n;
                if (bus.ack) break;
            end
            chk($sformatf("stream_interval_%0d", k), a_lat, (k == 0) ? LAT : LAT + 1);
            chk($sformatf("stream_data_%0d", k), bus.dat_sm, 32'(k));
            bus.adr = 32'(4 * (k + 1));
        end
        drive_idle();
        @(negedge clk);
        chk("stream_ack_single", {31'b0, bus.ack}, 32'd0);

        // Write to word 9 abandoned during the first wait cycle.
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
        bus.adr = 32'h24; bus.dat_ms = 32'hFFFFFFFF; bus.sel = 4'hF;
        @(negedge clk);
        drive_idle();
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack) seen = 1'b1;
        end
        chk("abort_no_ack", {31'b0, seen}, 32'd0);
        xfer(1'b0, 32'h24, 32'h0, 4'h0, a_ack, a_err, a_rd, a_lat);
        chk("abort_word_kept", a_rd, 32'h00000009);

        // Table of single transfers.
        for (int i = 0; i < NVEC; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, a_ack, a_err, a_rd, a_lat);
            chk($sformatf("vec%0d_resp", i), {30'b0, a_ack, a_err},
                vecs[i].exp_err ? 32'd1 : 32'd2);
            chk($sformatf("vec%0d_latency", i), a_lat, LAT);
            if (vecs[i].chk_dat) chk($sformatf("vec%0d_data", i), a_rd, vecs[i].exp_dat);
        end

        // stb without cyc is not a request.
        @(negedge clk);
        bus.cyc = 1'b0; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack || bus.err) seen = 1'b1;
        end
        drive_idle();
        chk("stb_without_cyc", {31'b0, seen}, 32'd0);

        // Reset in mid-read wipes written data and restarts the fill.
        xfer(1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, a_ack, a_err, a_rd, a_lat);
        chk("w3_write_acked", {31'b0, a_ack}, 32'd1);
        @(negedge clk);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0C;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ack",       {31'b0, bus.ack},   32'd0);
        chk("midrst_init_done", {31'b0, init_done}, 32'd0);
        chk("midrst_dat_sm",    bus.dat_sm,         32'd0);
        rst = 1'b0;
        drive_idle();
        n_done = 0;
        seen   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.ack) seen = 1'b1;
            if (init_done) begin n_done = n; break; end
        end
        chk("refill_cycles",  n_done,        32'd16);
        chk("midrst_no_ack",  {31'b0, seen}, 32'd0);
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, a_ack, a_err, a_rd, a_lat);
        chk("refill_word3", a_rd, 32'h00000003);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, a_ack, a_err, a_rd, a_lat);
        chk("refill_word2", a_rd, 32'h00000002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
